// File: rtl/otf_pkg.sv
// Shared definitions for the on-the-fly quotient converter: FSM encoding and digit-count bound.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package otf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_CORR  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Digits needed to fill a QW-bit quotient at LOG2R bits per digit
    function automatic int otf_maxd(input int qw, input int log2r);
        return (qw + log2r - 1) / log2r;
    endfunction

endpackage

// File: rtl/otf_digit_step.sv
// One on-the-fly conversion step: appends a signed-digit to Q and QM (QM tracks Q-1).
// Latency: combinational.
// Backpressure: none; the caller decides when the result is registered.
module otf_digit_step #(
    parameter int QW    = 32,
    parameter int LOG2R = 3
) (
    input  logic [QW-1:0]  q,
    input  logic [QW-1:0]  qm,
    input  logic [LOG2R:0] digit,
    output logic [QW-1:0]  q_nxt,
    output logic [QW-1:0]  qm_nxt
);

    localparam logic [LOG2R-1:0] ONE = LOG2R'(1);

    logic             sgn;
    logic [LOG2R-1:0] mag;

    assign sgn = digit[LOG2R];
    assign mag = digit[LOG2R-1:0];

    // Multiplying by R is a left concatenation; truncation drops the shifted-out MSBs.
    always_comb begin
        q_nxt  = q;
        qm_nxt = qm;
        if (mag == '0) begin
            q_nxt  = QW'({q,  {LOG2R{1'b0}}});
            qm_nxt = QW'({qm, {LOG2R{1'b1}}});
        end else if (!sgn) begin
            q_nxt  = QW'({q, mag});
            qm_nxt = QW'({q, LOG2R'(mag - ONE)});
        end else begin
            // R-m and R-m-1 reduced to LOG2R bits are -m and ~m
            q_nxt  = QW'({qm, LOG2R'(~mag + ONE)});
            qm_nxt = QW'({qm, ~mag});
        end
    end

endmodule

// File: rtl/otf_converter_p.sv
// Converts a stream of sign-magnitude quotient digits to a corrected binary quotient.
// Latency: done and q_out two cycles after the last digit when rem_valid follows immediately.
// Backpressure: none; digits/remainder are taken only in ACCUM/CORR, start aborts from any state.
module otf_converter_p
    import otf_pkg::*;
#(
    parameter  int QW    = 32,
    parameter  int LOG2R = 3,
    parameter  int MAXD  = otf_maxd(QW, LOG2R),
    localparam int NDW   = $clog2(MAXD + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             digit_valid,
    input  logic [LOG2R:0]   digit,
    input  logic             digit_last,
    input  logic             rem_valid,
    input  logic             rem_neg,
    output logic [QW-1:0]    q_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NDW-1:0]   ndig
);

    localparam logic [NDW-1:0] NDIG_LIMIT = NDW'(MAXD);
    localparam logic [NDW-1:0] NDIG_SAT   = NDW'(MAXD + 1);
    localparam logic [NDW-1:0] NDIG_ONE   = NDW'(1);

    state_t          state, state_nxt;
    logic [QW-1:0]   q_reg, qm_reg;
    logic [QW-1:0]   q_step, qm_step;
    logic            digit_acc, rem_acc;

    otf_digit_step #(
        .QW    (QW),
        .LOG2R (LOG2R)
    ) u_step (
        .q      (q_reg),
        .qm     (qm_reg),
        .digit  (digit),
        .q_nxt  (q_step),
        .qm_nxt (qm_step)
    );

    // start has priority, so a digit or remainder in the start cycle is dropped
    assign digit_acc = (state == ST_ACCUM) && digit_valid && !start;
    assign rem_acc   = (state == ST_CORR)  && rem_valid   && !start;
    assign busy      = (state == ST_ACCUM) || (state == ST_CORR);

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_ACCUM;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_ACCUM: if (digit_acc && digit_last) state_nxt = ST_CORR;
                ST_CORR:  if (rem_acc) state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg  <= '0;
            qm_reg <= '0;
            ndig   <= '0;
            err    <= 1'b0;
        end else if (start) begin
            q_reg  <= '0;
            qm_reg <= '1;
            ndig   <= '0;
            err    <= 1'b0;
        end else if (digit_acc) begin
            q_reg  <= q_step;
            qm_reg <= qm_step;
            if (ndig != NDIG_SAT) ndig <= ndig + NDIG_ONE;
            if (ndig == NDIG_LIMIT) err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_out <= '0;
            done  <= 1'b0;
        end else begin
            done <= rem_acc;
            if (rem_acc) q_out <= rem_neg ? qm_reg : q_reg;
        end
    end

endmodule

// File: tb/tb_otf_converter_p.sv
// Directed bench for otf_converter_p: arithmetic reference model plus a result scoreboard.
module tb_otf_converter_p;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        digit_last;
    logic        rem_valid;
    logic        rem_neg;
    logic [31:0] q_out;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  ndig;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mq, mqm;
    logic [31:0] sb[$];
    logic        prev_done = 1'b0;

    otf_converter_p #(.QW(32), .LOG2R(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .digit_valid (digit_valid),
        .digit       (digit),
        .digit_last  (digit_last),
        .rem_valid   (rem_valid),
        .rem_neg     (rem_neg),
        .q_out       (q_out),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .ndig        (ndig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference step written as plain radix-8 arithmetic modulo 2^32
    task automatic model_step(input logic sgn, input int mag);
        logic [31:0] nq, nqm;
        if (mag == 0) begin
            nq  = mq * 32'd8;
            nqm = mqm * 32'd8 + 32'd7;
        end else if (!sgn) begin
            nq  = mq * 32'd8 + 32'(mag);
            nqm = mq * 32'd8 + 32'(mag) - 32'd1;
        end else begin
            nq  = mqm * 32'd8 + 32'(8 - mag);
            nqm = mqm * 32'd8 + 32'(7 - mag);
        end
        mq  = nq;
        mqm = nqm;
    endtask

    task automatic do_start(input logic with_digit);
        start       = 1'b1;
        digit_valid = with_digit;
        rem_valid   = with_digit;
        digit       = 4'b0110;
        tick();
        start       = 1'b0;
        digit_valid = 1'b0;
        rem_valid   = 1'b0;
        mq  = 32'h0;
        mqm = 32'hFFFF_FFFF;
        chk("start_busy", busy, 1'b1);
        chk("start_ndig", ndig, 4'd0);
        chk("start_err", err, 1'b0);
        chk("start_q", dut.q_reg, mq);
        chk("start_qm", dut.qm_reg, mqm);
    endtask

    task automatic send_digit(input logic sgn, input int mag, input logic last);
        digit_valid = 1'b1;
        digit       = {sgn, 3'(mag)};
        digit_last  = last;
        tick();
        digit_valid = 1'b0;
        digit_last  = 1'b0;
        model_step(sgn, mag);
        chk("step_q", dut.q_reg, mq);
        chk("step_qm", dut.qm_reg, mqm);
    endtask

    task automatic finish_conv(input logic neg);
        chk("corr_busy", busy, 1'b1);
        chk("corr_no_done", done, 1'b0);
        rem_valid = 1'b1;
        rem_neg   = neg;
        sb.push_back(neg ? mqm : mq);
        tick();
        rem_valid = 1'b0;
        rem_neg   = 1'b0;
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b0);
        tick();
        chk("done_single", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    // Each done pulse must carry the result queued when the remainder sign was driven
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("done_has_expect", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) chk("q_out", q_out, sb.pop_front());
        end
        if (rst_n && done && prev_done) chk("done_twice", 1'b1, 1'b0);
        prev_done = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; digit_valid = 1'b0; digit = 4'b0;
        digit_last = 1'b0; rem_valid = 1'b0; rem_neg = 1'b0;
        mq = 32'h0; mqm = 32'h0;
        tick(); tick();
        chk("rst_q_out", q_out, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ndig", ndig, 4'd0);
        chk("rst_qm", dut.qm_reg, 32'h0);
        rst_n = 1'b1;
        tick();

        // +3, -2, +5 -> 181 / 180
        do_start(1'b0);
        send_digit(1'b0, 3, 1'b0);
        send_digit(1'b1, 2, 1'b0);
        send_digit(1'b0, 5, 1'b1);
        chk("t1_q", dut.q_reg, 32'd181);
        finish_conv(1'b0);
        chk("t1_q_out", q_out, 32'd181);

        do_start(1'b0);
        chk("t2_hold", q_out, 32'd181);
        send_digit(1'b0, 3, 1'b0);
        send_digit(1'b1, 2, 1'b0);
        send_digit(1'b0, 5, 1'b1);
        finish_conv(1'b1);
        chk("t2_q_out", q_out, 32'd180);

        // -1 then 0
        do_start(1'b0);
        send_digit(1'b1, 1, 1'b0);
        chk("t3_q1", dut.q_reg, 32'hFFFF_FFFF);
        chk("t3_qm1", dut.qm_reg, 32'hFFFF_FFFE);
        send_digit(1'b0, 0, 1'b1);
        chk("t3_q2", dut.q_reg, 32'hFFFF_FFF8);
        chk("t3_qm2", dut.qm_reg, 32'hFFFF_FFF7);
        finish_conv(1'b0);
        chk("t3_q_out", q_out, 32'hFFFF_FFF8);

        // Twelve +7 digits: overflow on the twelfth acceptance
        do_start(1'b0);
        for (int i = 0; i < 11; i++) send_digit(1'b0, 7, 1'b0);
        chk("t4_err_before", err, 1'b0);
        chk("t4_ndig11", ndig, 4'd11);
        send_digit(1'b0, 7, 1'b1);
        chk("t4_err", err, 1'b1);
        chk("t4_ndig12", ndig, 4'd12);
        finish_conv(1'b0);
        chk("t4_q_out", q_out, 32'hFFFF_FFFF);
        chk("t4_err_sticky", err, 1'b1);
        do_start(1'b0);
        chk("t4_err_clr", err, 1'b0);

        // Abort mid-ACCUM with a digit and a remainder present in the start cycle
        send_digit(1'b0, 4, 1'b0);
        send_digit(1'b0, 4, 1'b0);
        chk("t5_ndig2", ndig, 4'd2);
        do_start(1'b1);
        chk("t5_hold", q_out, 32'hFFFF_FFFF);
        send_digit(1'b0, 1, 1'b1);
        chk("t5_hold_corr", q_out, 32'hFFFF_FFFF);
        finish_conv(1'b0);
        chk("t5_q_out", q_out, 32'd1);

        // Asynchronous reset while in CORR
        do_start(1'b0);
        send_digit(1'b0, 2, 1'b1);
        chk("t6_corr_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_q_out", q_out, 32'h0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_ndig", ndig, 4'd0);
        chk("t6_rst_done", done, 1'b0);
        tick();
        rst_n     = 1'b1;
        rem_valid = 1'b1;
        digit_valid = 1'b1;
        digit     = 4'b0011;
        tick();
        tick();
        rem_valid   = 1'b0;
        digit_valid = 1'b0;
        chk("t6_no_done", done, 1'b0);
        chk("t6_idle_ndig", ndig, 4'd0);
        chk("t6_idle_q_out", q_out, 32'h0);
        do_start(1'b0);
        send_digit(1'b1, 0, 1'b0);
        chk("t6_negzero_q", dut.q_reg, 32'h0);
        chk("t6_negzero_qm", dut.qm_reg, 32'hFFFF_FFFF);
        chk("t6_ndig1", ndig, 4'd1);
        tick();
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
